// File: rtl/mem_access_unit.sv
// Load/store stage between the multicycle control FSM and a single-port word memory.
// Checks legality/alignment, drives a req/ready bus with lane strobes, extends loads.
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        MemWrite,
    input  logic [2:0]  MemOp,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ReadData,
    output logic        done,
    output logic        busy,
    output logic        err
);

    localparam bit             TO_EN     = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t           state, state_nxt;
    logic             we_q;
    logic [2:0]       op_q;
    logic [1:0]       off_q;
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic [3:0]       wstrb_q;
    logic [31:0]      addr_q, wdata_q, rdata_q;

    logic             legal;
    logic [3:0]       st_strb;
    logic [31:0]      st_data;
    logic             timeout_hit;
    logic [31:0]      ld_shift;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;

    // Legality and alignment of the incoming request
    always_comb begin
        legal = 1'b0;
        case (MemOp)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~addr[0];
            3'b010:  legal = (addr[1:0] == 2'b00);
            3'b100:  legal = ~MemWrite;
            3'b101:  legal = ~MemWrite & ~addr[0];
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        st_strb = 4'b1111;
        st_data = wdata;
        case (MemOp[1:0])
            2'b00: begin
                st_strb = 4'b0001 << addr[1:0];
                st_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << {addr[1], 1'b0};
                st_data = {2{wdata[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = wdata;
            end
        endcase
        if (!MemWrite)
            st_strb = 4'b0000;
    end

    assign timeout_hit = TO_EN && (cnt == CNT_LIMIT);

    // Load lane extraction from the returned word
    assign ld_shift = mem_rdata >> {off_q, 3'b000};
    assign ld_half  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (op_q)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_shift[7:0]};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = legal ? REQ : DONE;
            REQ:  if (mem_ready || timeout_hit) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            op_q    <= 3'b000;
            off_q   <= 2'b00;
            cnt     <= '0;
            err_q   <= 1'b0;
            wstrb_q <= 4'b0000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    we_q    <= MemWrite;
                    op_q    <= MemOp;
                    off_q   <= addr[1:0];
                    addr_q  <= {addr[31:2], 2'b00};
                    wdata_q <= st_data;
                    wstrb_q <= st_strb;
                    err_q   <= ~legal;
                    cnt     <= '0;
                end
                REQ: begin
                    if (mem_ready) begin
                        err_q <= 1'b0;
                        if (!we_q)
                            rdata_q <= ld_data;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: cnt <= '0;
                default: cnt <= '0;
            endcase
        end
    end

    // All outputs decode flops only; mem_ready never reaches mem_req combinationally
    always_comb begin
        mem_req   = (state == REQ);
        mem_we    = mem_req & we_q;
        mem_wstrb = mem_req ? wstrb_q : 4'b0000;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        ReadData  = rdata_q;
        done      = (state == DONE);
        busy      = (state != IDLE);
        err       = done & err_q;
    end

endmodule
